// File: rtl/store_trace_pkg.sv
// Shared types and constants for the store trace monitor.
// MISR helper is used only when STORE_TRACE_MISR_EN is defined.
package store_trace_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  function automatic logic [31:0] misr_next(input logic [31:0] sig, input entry_t e);
    return ({sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0)) ^ e.addr ^ e.data;
  endfunction

endpackage

// File: rtl/store_trace_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers for full/empty.
// Push into a full FIFO and pop from an empty one are ignored here.
module store_trace_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = wr_ptr - rd_ptr;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/store_trace_monitor.sv
// Windowed capture of execute-stage stores into a FWFT buffer, with drop
// accounting and an optional MISR signature (define STORE_TRACE_MISR_EN).
module store_trace_monitor
  import store_trace_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CNT_W-1:0]             run_cycles,
  input  logic                         MemWriteX,
  input  logic [ADDR_W-1:0]            ALUResultX,
  input  logic [DATA_W-1:0]            RD2X,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [CNT_W-1:0]             drop_count,
  output logic [31:0]                  signature
);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic             arm, observe, full, empty;

  assign arm     = start && (state != ARMED);
  assign observe = (state == ARMED) && MemWriteX;
  assign busy    = (state == ARMED);
  assign done    = (state == DONE);
  assign rd_valid = !empty;

  store_trace_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (observe),
    .pop   (rd_valid && rd_ready),
    .wdata ({ALUResultX, RD2X}),
    .rdata ({rd_addr, rd_data}),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (run_cycles == '0) ? DONE : ARMED;
      ARMED:      if (remaining == CNT_W'(1)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining  <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (arm)                 remaining <= run_cycles;
      else if (state == ARMED) remaining <= remaining - 1'b1;
      // Full is judged before any same-cycle pop, so a popping full FIFO still drops.
      if (arm) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end else if (observe && full) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

`ifdef STORE_TRACE_MISR_EN
  entry_t      obs_e;
  logic [31:0] sig_q;

  assign obs_e     = '{addr: 32'(ALUResultX), data: 32'(RD2X)};
  assign signature = sig_q;

  // Dropped stores still fold in, so the signature covers everything observed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       sig_q <= MISR_SEED;
    else if (arm)     sig_q <= MISR_SEED;
    else if (observe) sig_q <= misr_next(sig_q, obs_e);
  end
`else
  assign signature = 32'h0;
`endif

endmodule

// File: doc/store_trace_monitor.md
# store_trace_monitor

Parametrised, synthesizable store-observation unit for the 6-stage processor. It taps the execute-stage store port (MemWriteX, ALUResultX, RD2X) for a programmable cycle window and buffers each store (address, data) in a FIFO. The buffer is drained through a valid/ready readout port, and the unit optionally folds every observed store into a 32-bit MISR signature. It replaces manual run-N-cycles-and-stop bench control with a self-terminating capture that simulation and on-chip debug can both use.

## Interface
- ADDR_W, 32, store address width (≤32)
- DATA_W, 32, store data width (≤32)
- DEPTH, 16, FIFO entries; power of two, ≥2
- CNT_W, 16, run-cycle budget / drop counter width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; arms capture from IDLE or DONE
- run_cycles  in  CNT_W  capture window length in cycles; sampled on start
- MemWriteX  in  1  store valid
- ALUResultX  in  ADDR_W  store address
- RD2X  in  DATA_W  store data
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  consumer accepts head entry
- rd_addr  out  ADDR_W  head entry address
- rd_data  out  DATA_W  head entry data
- level  out  $clog2(DEPTH+1)  current occupancy
- busy  out  1  state == ARMED
- done  out  1  state == DONE
- overflow  out  1  sticky: at least one store dropped since last start
- drop_count  out  CNT_W  dropped stores, saturating
- signature  out  32  MISR value

## Operation
- States: IDLE (after reset), ARMED, DONE.
- IDLE → ARMED on start; remaining ← run_cycles. If run_cycles == 0, go directly to DONE.
- ARMED: remaining decrements each cycle. On the cycle remaining == 1, that cycle's store is still observed, then → DONE.
- DONE → ARMED on start. start while ARMED is ignored.
- On start: overflow, drop_count and signature clear/reseed. The FIFO is NOT flushed, so earlier entries remain readable.
- Capture happens only in ARMED with MemWriteX = 1:
  - Not full: push {ALUResultX, RD2X}.
  - Full: drop the store, set overflow, increment drop_count (saturates at all-ones).
- Full is evaluated before a same-cycle pop. A push into a full FIFO is rejected even when rd_ready pops that cycle.
- Readout is first-word-fall-through:
  - rd_addr/rd_data show the head entry whenever rd_valid = 1.
  - A pop occurs when rd_valid && rd_ready.
  - rd_ready while empty has no effect.
  - Readout is legal in every state.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. Full/empty are decided by MSB comparison.
- Simultaneous push and pop on a non-empty, non-full FIFO: level unchanged.
- MISR (when enabled):
  - Seed is 32'hFFFF_FFFF; it is reseeded on start.
  - Advances once per observed store in ARMED, including dropped stores.
  - sig_next = ((sig << 1) ^ (sig[31] ? 32'h04C1_1DB7 : 0)) ^ zext(addr) ^ zext(data).

## Timing
- Reset values: rd_valid 0, level 0, busy 0, done 0, overflow 0, drop_count 0, signature 32'hFFFF_FFFF, state IDLE. rd_addr/rd_data read 0 while empty.
- Store at edge N → rd_valid and level updated after edge N (visible in cycle N+1).
- Pop at edge N → next head visible in cycle N+1.
- start at edge N → busy = 1 in cycle N+1. A window of run_cycles = K observes exactly K edges, and done asserts after the K-th edge.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to reset values, and FIFO contents are discarded.

## Configuration
- STORE_TRACE_MISR_EN defined: MISR register and logic present; signature behaves as specified.
- STORE_TRACE_MISR_EN undefined: no MISR flops; signature is tied to 32'h0. All other behaviour is identical.

## Structure
- Package store_trace_pkg holds:
  - state enum (IDLE, ARMED, DONE)
  - packed entry struct {addr, data}
  - MISR_POLY = 32'h04C1_1DB7
  - MISR_SEED = 32'hFFFF_FFFF
- One sub-module, store_trace_fifo: parametrised FWFT FIFO with push, pop, full, empty and level. The top level holds the FSM, counters and MISR.

## Test plan
- Reset, start with run_cycles=5, one store addr 0x0 / data 0x0 in cycle 1 → level 1, rd_addr 0, rd_data 0, signature 32'hFB3E_E249, done after the 5th edge.
- DEPTH=16, 20 consecutive stores in ARMED with rd_ready=0 → level 16, overflow 1, drop_count 4; draining returns the first 16 in order.
- FIFO full, MemWriteX=1 and rd_ready=1 in the same cycle → pop occurs, push rejected, level 15, drop_count +1.
- Store in the cycle after done asserts → ignored: level, signature and drop_count unchanged.
- Reset deasserted then asserted low mid-ARMED with level 7 → all outputs at reset values immediately; level 0, rd_valid 0.
- Build without STORE_TRACE_MISR_EN and repeat the first scenario → signature 0, all other outputs identical.
